// File: rtl/flags_pkg.sv
// -----------------------------------------------------------------------------
// flags_pkg
// Shared definitions for the CPU status-flag unit.
//   FLAG_C .. FLAG_V : bit positions inside the flag vector ([4]=V ... [0]=C)
//   FLAG_W           : flag vector width
//   flags_t          : flag vector type
//   carry_sel_e      : carry-select codes carried alongside the flags
//   overflow_bit()   : signed-overflow rule for add and subtract
// -----------------------------------------------------------------------------
package flags_pkg;

    localparam int FLAG_C = 0;
    localparam int FLAG_L = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_S = 3;
    localparam int FLAG_V = 4;
    localparam int FLAG_W = 5;

    typedef logic [FLAG_W-1:0] flags_t;

    // Carry-select codes; the flag unit only delays them by one cycle so the
    // downstream carry mux lines up with the registered flags.
    typedef enum logic [1:0] {
        CSEL_ARITH = 2'b00,
        CSEL_LOGIC = 2'b01,
        CSEL_ZERO  = 2'b10,
        CSEL_ONE   = 2'b11
    } carry_sel_e;

    // Signed overflow from operand/result sign bits only.
    //   add: both operands differ in sign from the result
    //   sub: operands differ in sign and the result differs from lhs
    function automatic logic overflow_bit(input logic lhs_msb,
                                          input logic rhs_msb,
                                          input logic res_msb,
                                          input logic is_sub);
        if (is_sub) begin
            return (lhs_msb ^ rhs_msb) & (lhs_msb ^ res_msb);
        end
        return (lhs_msb ^ res_msb) & (rhs_msb ^ res_msb);
    endfunction

endpackage

// File: rtl/flag_stack.sv
// -----------------------------------------------------------------------------
// flag_stack
// LIFO save stack for the flag vector (interrupt entry/return).
//   clk, rst   : clock, synchronous active-high reset (clears the level only)
//   push_i     : save data_i onto the stack
//   pop_i      : release the top entry (top_o is valid when pop_ok_o=1)
//   data_i     : value to save
//   top_o      : current top entry (mem[level-1])
//   pop_ok_o   : a legal pop or swap happens this cycle; consumer takes top_o
//   level_o    : number of valid entries
//   full_o     : level_o == DEPTH
//   empty_o    : level_o == 0
//   ovf_o      : pulse, push attempted while full
//   unf_o      : pulse, pop attempted while empty
// push & pop together: swap when not empty, otherwise push plus underflow.
// -----------------------------------------------------------------------------
module flag_stack
    import flags_pkg::*;
#(
    parameter int WIDTH = FLAG_W,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [WIDTH-1:0]             data_i,
    output logic [WIDTH-1:0]             top_o,
    output logic                         pop_ok_o,
    output logic [$clog2(DEPTH+1)-1:0]   level_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic                         ovf_o,
    output logic                         unf_o
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [LW-1:0]    level_q;
    logic [LW-1:0]    level_d;
    logic [IW-1:0]    top_idx;
    logic [IW-1:0]    wr_idx;
    logic             mem_we;
    logic             full;
    logic             empty;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LW'(DEPTH));
    // Wraps when empty; top_o is then meaningless and pop_ok_o stays low.
    assign top_idx = IW'(level_q - LW'(1));

    // NOTE: combinational blocks use blocking '=' and give every output a
    // default first, so no path leaves a signal unassigned and no latch forms.
    always_comb begin
        level_d  = level_q;
        mem_we   = 1'b0;
        wr_idx   = IW'(level_q);
        pop_ok_o = 1'b0;
        ovf_o    = 1'b0;
        unf_o    = 1'b0;
        case ({push_i, pop_i})
            2'b11: begin
                if (empty) begin
                    // Nothing to pop: behaves as a plain push, flagged as underflow.
                    mem_we  = 1'b1;
                    level_d = level_q + LW'(1);
                    unf_o   = 1'b1;
                end else begin
                    // Swap: overwrite the top in place, level unchanged.
                    mem_we   = 1'b1;
                    wr_idx   = top_idx;
                    pop_ok_o = 1'b1;
                end
            end
            2'b10: begin
                if (full) begin
                    ovf_o = 1'b1;
                end else begin
                    mem_we  = 1'b1;
                    level_d = level_q + LW'(1);
                end
            end
            2'b01: begin
                if (empty) begin
                    unf_o = 1'b1;
                end else begin
                    pop_ok_o = 1'b1;
                    level_d  = level_q - LW'(1);
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state is written with non-blocking '<=' so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; the level counter
    // alone defines which entries are valid, and a reset-free array maps to
    // plain RAM/register-file cells.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem_q[wr_idx] <= data_i;
        end
    end

    assign top_o   = mem_q[top_idx];
    assign level_o = level_q;
    assign full_o  = full;
    assign empty_o = empty;

endmodule

// File: rtl/flag_unit.sv
// -----------------------------------------------------------------------------
// flag_unit
// Registered CPU status flags, placed after the ALU stage. One-cycle latency,
// no combinational input->output path.
//   clk, rst          : clock, synchronous active-high reset
//   upd_valid         : ALU result valid; apply masked update
//   upd_mask[4:0]     : per-flag update enable (V,S,Z,L,C)
//   alu_result/lhs/rhs: ALU result and operands (DATA_WIDTH, MSB = sign)
//   alu_is_sub        : select subtract overflow rule
//   arith_carry_in    : ALU carry/borrow -> C
//   logic_carry_in    : shifter carry-out -> L
//   carry_sel_in[1:0] : carry-select code, delayed one cycle to carry_sel_q
//   wr_en, wr_data    : direct write of the whole flag vector
//   push, pop         : save/restore flags via the LIFO stack
//   flags_q           : registered flag vector
//   carry_sel_q       : carry_sel_in delayed one cycle
//   stack_level       : valid stack entries
//   stack_full/empty  : stack status
//   stk_err[1:0]      : sticky errors, [1]=overflow, [0]=underflow
// Next-flag priority: legal pop > wr_en > upd_valid > hold.
// DATA_WIDTH must be at least 2.
// -----------------------------------------------------------------------------
module flag_unit
    import flags_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int STACK_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               upd_valid,
    input  logic [FLAG_W-1:0]                  upd_mask,
    input  logic [DATA_WIDTH-1:0]              alu_result,
    input  logic [DATA_WIDTH-1:0]              alu_lhs,
    input  logic [DATA_WIDTH-1:0]              alu_rhs,
    input  logic                               alu_is_sub,
    input  logic                               arith_carry_in,
    input  logic                               logic_carry_in,
    input  logic [1:0]                         carry_sel_in,
    input  logic                               wr_en,
    input  logic [FLAG_W-1:0]                  wr_data,
    input  logic                               push,
    input  logic                               pop,
    output logic [FLAG_W-1:0]                  flags_q,
    output logic [1:0]                         carry_sel_q,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_level,
    output logic                               stack_full,
    output logic                               stack_empty,
    output logic [1:0]                         stk_err
);

    localparam int MSB = DATA_WIDTH - 1;

    flags_t     computed;
    flags_t     upd_merged;
    flags_t     flags_d;
    flags_t     stack_top;
    logic [1:0] stk_err_d;
    logic       pop_ok;
    logic       stk_ovf;
    logic       stk_unf;

    // Overflow needs only the operand sign bits; the rest of each operand is
    // folded here so the unused bits are visibly accounted for.
    logic unused_operand_bits;
    assign unused_operand_bits = ^{alu_lhs[MSB-1:0], alu_rhs[MSB-1:0]};

    flag_stack #(
        .WIDTH (FLAG_W),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk      (clk),
        .rst      (rst),
        .push_i   (push),
        .pop_i    (pop),
        .data_i   (flags_q),      // saves the pre-update flags
        .top_o    (stack_top),
        .pop_ok_o (pop_ok),
        .level_o  (stack_level),
        .full_o   (stack_full),
        .empty_o  (stack_empty),
        .ovf_o    (stk_ovf),
        .unf_o    (stk_unf)
    );

    always_comb begin
        computed         = '0;
        computed[FLAG_C] = arith_carry_in;
        computed[FLAG_L] = logic_carry_in;
        computed[FLAG_Z] = ~|alu_result;
        computed[FLAG_S] = alu_result[MSB];
        computed[FLAG_V] = overflow_bit(alu_lhs[MSB], alu_rhs[MSB],
                                        alu_result[MSB], alu_is_sub);
    end

    // Masked bits take the new value, unmasked bits keep the current flags.
    assign upd_merged = (flags_q & ~upd_mask) | (computed & upd_mask);

    always_comb begin
        flags_d = flags_q;
        if (pop_ok) begin
            flags_d = stack_top;
        end else if (wr_en) begin
            flags_d = wr_data;
        end else if (upd_valid) begin
            flags_d = upd_merged;
        end
    end

    assign stk_err_d = stk_err | {stk_ovf, stk_unf};

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q     <= '0;
            carry_sel_q <= 2'b00;
            stk_err     <= 2'b00;
        end else begin
            flags_q     <= flags_d;
            carry_sel_q <= carry_sel_in;
            stk_err     <= stk_err_d;
        end
    end

endmodule

// File: tb/tb_flag_unit.sv
// -----------------------------------------------------------------------------
// tb_flag_unit
// Table-driven bench for flag_unit (DATA_WIDTH=16, STACK_DEPTH=4). Each record
// is one clock cycle of inputs plus the expected registered outputs after it.
// -----------------------------------------------------------------------------
module tb_flag_unit;

    logic        clk;
    logic        rst;
    logic        upd_valid;
    logic [4:0]  upd_mask;
    logic [15:0] alu_result;
    logic [15:0] alu_lhs;
    logic [15:0] alu_rhs;
    logic        alu_is_sub;
    logic        arith_carry_in;
    logic        logic_carry_in;
    logic [1:0]  carry_sel_in;
    logic        wr_en;
    logic [4:0]  wr_data;
    logic        push;
    logic        pop;
    logic [4:0]  flags_q;
    logic [1:0]  carry_sel_q;
    logic [2:0]  stack_level;
    logic        stack_full;
    logic        stack_empty;
    logic [1:0]  stk_err;

    int checks = 0;
    int errors = 0;

    flag_unit #(
        .DATA_WIDTH  (16),
        .STACK_DEPTH (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .upd_valid      (upd_valid),
        .upd_mask       (upd_mask),
        .alu_result     (alu_result),
        .alu_lhs        (alu_lhs),
        .alu_rhs        (alu_rhs),
        .alu_is_sub     (alu_is_sub),
        .arith_carry_in (arith_carry_in),
        .logic_carry_in (logic_carry_in),
        .carry_sel_in   (carry_sel_in),
        .wr_en          (wr_en),
        .wr_data        (wr_data),
        .push           (push),
        .pop            (pop),
        .flags_q        (flags_q),
        .carry_sel_q    (carry_sel_q),
        .stack_level    (stack_level),
        .stack_full     (stack_full),
        .stack_empty    (stack_empty),
        .stk_err        (stk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        upd;
        logic [4:0]  mask;
        logic [15:0] res;
        logic [15:0] lhs;
        logic [15:0] rhs;
        logic        sub;
        logic        ac;
        logic        lc;
        logic [1:0]  csel;
        logic        wr;
        logic [4:0]  wd;
        logic        push;
        logic        pop;
        logic [4:0]  e_flags;
        logic [1:0]  e_csel;
        logic [2:0]  e_lvl;
        logic [1:0]  e_err;
    } vec_t;

    vec_t vecs[$];

    // ALU-update cycle with the stack idle.
    function automatic vec_t alu(input logic [4:0] mask, input logic [15:0] res,
                                 input logic [15:0] lhs, input logic [15:0] rhs,
                                 input logic sub, input logic ac, input logic lc,
                                 input logic [1:0] csel, input logic [4:0] e_flags,
                                 input logic [2:0] e_lvl, input logic [1:0] e_err);
        vec_t v;
        v = '{rst: 1'b0, upd: 1'b1, mask: mask, res: res, lhs: lhs, rhs: rhs,
              sub: sub, ac: ac, lc: lc, csel: csel, wr: 1'b0, wd: 5'h00,
              push: 1'b0, pop: 1'b0, e_flags: e_flags, e_csel: csel,
              e_lvl: e_lvl, e_err: e_err};
        return v;
    endfunction

    // Control cycle: reset / direct write / push / pop, no ALU update.
    function automatic vec_t ctl(input logic r, input logic wr, input logic [4:0] wd,
                                 input logic pu, input logic po, input logic [1:0] csel,
                                 input logic [4:0] e_flags, input logic [1:0] e_csel,
                                 input logic [2:0] e_lvl, input logic [1:0] e_err);
        vec_t v;
        v = '{rst: r, upd: 1'b0, mask: 5'h00, res: 16'h0, lhs: 16'h0, rhs: 16'h0,
              sub: 1'b0, ac: 1'b0, lc: 1'b0, csel: csel, wr: wr, wd: wd,
              push: pu, pop: po, e_flags: e_flags, e_csel: e_csel,
              e_lvl: e_lvl, e_err: e_err};
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input string tag);
        rst            = v.rst;
        upd_valid      = v.upd;
        upd_mask       = v.mask;
        alu_result     = v.res;
        alu_lhs        = v.lhs;
        alu_rhs        = v.rhs;
        alu_is_sub     = v.sub;
        arith_carry_in = v.ac;
        logic_carry_in = v.lc;
        carry_sel_in   = v.csel;
        wr_en          = v.wr;
        wr_data        = v.wd;
        push           = v.push;
        pop            = v.pop;
        @(posedge clk);
        #1;
        check({tag, " flags"}, 16'(flags_q), 16'(v.e_flags));
        check({tag, " csel"},  16'(carry_sel_q), 16'(v.e_csel));
        check({tag, " level"}, 16'(stack_level), 16'(v.e_lvl));
        check({tag, " err"},   16'(stk_err), 16'(v.e_err));
        check({tag, " full"},  16'(stack_full), 16'(v.e_lvl == 3'd4));
        check({tag, " empty"}, 16'(stack_empty), 16'(v.e_lvl == 3'd0));
    endtask

    initial begin
        vec_t v;

        rst = 1'b1; upd_valid = 1'b0; upd_mask = '0; alu_result = '0;
        alu_lhs = '0; alu_rhs = '0; alu_is_sub = 1'b0; arith_carry_in = 1'b0;
        logic_carry_in = 1'b0; carry_sel_in = '0; wr_en = 1'b0; wr_data = '0;
        push = 1'b0; pop = 1'b0;

        // Reset beats push and wr_en in the same cycle.
        vecs.push_back(ctl(1, 1, 5'h1F, 1, 0, 2'd3, 5'h00, 2'd0, 3'd0, 2'b00));
        // add 7FFF+1=8000: V=1 S=1 Z=0 L=1 C=0
        vecs.push_back(alu(5'h1F, 16'h8000, 16'h7FFF, 16'h0001, 0, 0, 1, 2'd1, 5'h1A, 0, 0));
        // sub 8000-1=7FFF: V=1 S=0 Z=0 L=0 C=1
        vecs.push_back(alu(5'h1F, 16'h7FFF, 16'h8000, 16'h0001, 1, 1, 0, 2'd2, 5'h11, 0, 0));
        // Z-only update with res=0: C and V held, L/S untouched
        vecs.push_back(alu(5'h04, 16'h0000, 16'h1234, 16'h1234, 1, 0, 1, 2'd0, 5'h15, 0, 0));
        // add 8000+8000=0: V=1 S=0 Z=1 L=1 C=1
        vecs.push_back(alu(5'h1F, 16'h0000, 16'h8000, 16'h8000, 0, 1, 1, 2'd3, 5'h17, 0, 0));
        // sub 5-3=2: no overflow, only C
        vecs.push_back(alu(5'h1F, 16'h0002, 16'h0005, 16'h0003, 1, 1, 0, 2'd0, 5'h01, 0, 0));
        // mask 0: everything holds
        vecs.push_back(alu(5'h00, 16'h0000, 16'hFFFF, 16'hFFFF, 0, 0, 1, 2'd1, 5'h01, 0, 0));
        // S only
        vecs.push_back(alu(5'h08, 16'h8000, 16'h0000, 16'h0000, 0, 0, 0, 2'd2, 5'h09, 0, 0));
        // wr_en beats a concurrent full-mask update
        v = ctl(0, 1, 5'h01, 0, 0, 2'd0, 5'h01, 2'd0, 3'd0, 2'b00);
        v.upd = 1'b1; v.mask = 5'h1F;
        vecs.push_back(v);
        // push saves pre-update flags while wr_en still applies
        vecs.push_back(ctl(0, 1, 5'h02, 1, 0, 2'd0, 5'h02, 2'd0, 3'd1, 2'b00));
        vecs.push_back(ctl(0, 1, 5'h03, 1, 0, 2'd0, 5'h03, 2'd0, 3'd2, 2'b00));
        // legal pop beats wr_en and upd_valid
        v = ctl(0, 1, 5'h1F, 0, 1, 2'd0, 5'h02, 2'd0, 3'd1, 2'b00);
        v.upd = 1'b1; v.mask = 5'h1F;
        vecs.push_back(v);
        vecs.push_back(ctl(0, 0, 5'h00, 0, 1, 2'd0, 5'h01, 2'd0, 3'd0, 2'b00));
        // fill to full, then overflow push (write still lands)
        vecs.push_back(ctl(0, 1, 5'h04, 1, 0, 2'd0, 5'h04, 2'd0, 3'd1, 2'b00));
        vecs.push_back(ctl(0, 1, 5'h08, 1, 0, 2'd0, 5'h08, 2'd0, 3'd2, 2'b00));
        vecs.push_back(ctl(0, 1, 5'h10, 1, 0, 2'd0, 5'h10, 2'd0, 3'd3, 2'b00));
        vecs.push_back(ctl(0, 1, 5'h0C, 1, 0, 2'd0, 5'h0C, 2'd0, 3'd4, 2'b00));
        vecs.push_back(ctl(0, 1, 5'h1E, 1, 0, 2'd0, 5'h1E, 2'd0, 3'd4, 2'b10));
        // drain, then underflow pop with flags holding
        vecs.push_back(ctl(0, 0, 5'h00, 0, 1, 2'd0, 5'h10, 2'd0, 3'd3, 2'b10));
        vecs.push_back(ctl(0, 0, 5'h00, 0, 1, 2'd0, 5'h08, 2'd0, 3'd2, 2'b10));
        vecs.push_back(ctl(0, 0, 5'h00, 0, 1, 2'd0, 5'h04, 2'd0, 3'd1, 2'b10));
        vecs.push_back(ctl(0, 0, 5'h00, 0, 1, 2'd0, 5'h01, 2'd0, 3'd0, 2'b10));
        vecs.push_back(ctl(0, 0, 5'h00, 0, 1, 2'd0, 5'h01, 2'd0, 3'd0, 2'b11));
        // swap at level 1: top=0A, flags=15
        vecs.push_back(ctl(0, 1, 5'h0A, 0, 0, 2'd0, 5'h0A, 2'd0, 3'd0, 2'b11));
        vecs.push_back(ctl(0, 1, 5'h15, 1, 0, 2'd0, 5'h15, 2'd0, 3'd1, 2'b11));
        vecs.push_back(ctl(0, 0, 5'h00, 1, 1, 2'd2, 5'h0A, 2'd2, 3'd1, 2'b11));
        vecs.push_back(ctl(0, 0, 5'h00, 0, 1, 2'd0, 5'h15, 2'd0, 3'd0, 2'b11));

        foreach (vecs[i]) begin
            step(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of a push&pop at level 1 clears everything.
        step(ctl(0, 1, 5'h07, 1, 0, 2'd1, 5'h07, 2'd1, 3'd1, 2'b11), "seq_a0");
        step(ctl(1, 1, 5'h1F, 1, 1, 2'd3, 5'h00, 2'd0, 3'd0, 2'b00), "seq_a1");
        // push&pop at level 0: push only, underflow flagged, wr_en applies.
        step(ctl(0, 1, 5'h07, 0, 0, 2'd0, 5'h07, 2'd0, 3'd0, 2'b00), "seq_b0");
        step(ctl(0, 1, 5'h09, 1, 1, 2'd0, 5'h09, 2'd0, 3'd1, 2'b01), "seq_b1");
        step(ctl(0, 0, 5'h00, 0, 1, 2'd1, 5'h07, 2'd1, 3'd0, 2'b01), "seq_b2");
        // Sticky error survives idle cycles; flags hold.
        step(ctl(0, 0, 5'h00, 0, 0, 2'd0, 5'h07, 2'd0, 3'd0, 2'b01), "seq_b3");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
